dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  DM-stage data-memory responder: consumes EX/DM load/store requests and runs them on a ready/valid memory bus.
//  - Store path: little-endian byte-lane alignment.
//  - Load path: lane extraction with sign or zero extension.
//  - Holds the pipeline with stall_o until the access completes. Loaded data goes to the DM/WB register.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles allowed in REQ+WAIT before bus error abort (1..65535)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  dm_re_i        in   1   load request from EX/DM
//  dm_we_i        in   1   store request from EX/DM (priority over dm_re_i if both)
//  addr_i         in   32  byte address
//  wdata_i        in   32  store data (p1), right-justified
//  word_size_i    in   wrd_size_t  BYTE/HALF/WORD (common::)
//  sign_i         in   1   1=sign-extend load, 0=zero-extend
//  mem_req_o      out  1   bus request valid
//  mem_we_o       out  1   bus write
//  mem_addr_o     out  32  word address {addr[31:2],2'b00}
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  lane-replicated store data
//  mem_gnt_i      in   1   bus accepts request this cycle
//  mem_rvalid_i   in   1   read data valid
//  mem_rdata_i    in   32  read data word
//  stall_o        out  1   hold IF..DM stages
//  rdata_o        out  32  extended load result
//  rdata_vld_o    out  1   1-cycle pulse: rdata_o updated
//  misalign_o     out  1   1-cycle pulse: misaligned access dropped
//  bus_err_o      out  1   1-cycle pulse: timeout abort
// BEHAVIOUR
//  - Reset: state=IDLE, every output 0, timeout counter 0.
//  - FSM IDLE->REQ->(WAIT)->DONE->IDLE.
//  - IDLE, aligned request: latch addr/be/wdata/we/size/sign, go to REQ.
//    - stall_o=1 combinationally in this same cycle.
//  - IDLE, misaligned request: no bus access, stay in IDLE, misalign_o=1 next cycle, stall_o=0.
//    - HALF with addr[0]=1 is misaligned.
//    - WORD with addr[1:0]!=0 is misaligned.
//  - REQ: mem_req_o=1, outputs stable until mem_gnt_i. On grant: store->DONE, load->WAIT.
//  - WAIT: mem_req_o=0. On mem_rvalid_i: extract lane, extend, register into rdata_o, go to DONE.
//    - rvalid coinciding with the grant cycle is ignored; a response is expected only after the grant.
//  - DONE: stall_o=0; rdata_vld_o=1 for loads. Request inputs are ignored this cycle; next IDLE sees the new instruction.
//  - stall_o=1 in REQ and WAIT. Minimum latency: load 3 cycles, store 2 cycles.
//  - Byte lanes:
//    - BYTE: be=4'b0001<<addr[1:0], wdata={4{w[7:0]}}.
//    - HALF: be=4'b0011<<{addr[1],1'b0}, wdata={2{w[15:0]}}.
//    - WORD: be=4'hF.
//  - Load extract: lane selected by latched addr[1:0]; bits above size = sign ? msb : 0.
//  - rdata_o holds its last value until the next load completes; it is cleared to 0 on a timeout abort.
//  - Timeout: counter counts cycles in REQ+WAIT and clears on entry to REQ. When it reaches TIMEOUT_CYC:
//    - bus_err_o pulses.
//    - go to DONE; rdata_o=0; rdata_vld_o=0.
//    - mem_req_o drops. A later stray rvalid/gnt is ignored while not in the matching state.
//  - Reset mid-access: immediate return to IDLE and outputs 0; an outstanding bus transaction is abandoned.
// CONFIGURATION
//  DMEM_WBUF_EN defined: 1-entry posted store buffer.
//    - IDLE store with buffer empty: captured into the buffer, stall_o=0, drains via REQ independently.
//    - Any request while the buffer is draining stalls until the drain grant.
//    - Loads always wait for the drain grant, so there is no RAW bypass.
//  DMEM_WBUF_EN undefined: stores stall through REQ as above.
// TESTING
//  - Reset: assert rst_n=0 mid-REQ -> all outputs 0, next access starts clean from IDLE.
//  - LB signed: addr=0x103, mem_rdata=0x80FF_1234 -> be n/a, rdata_o=0xFFFF_FF80, rdata_vld_o pulse, stall 3 cycles with gnt/rvalid 1-cycle.
//  - SH: addr=0x202, w=0x0000_BEEF -> mem_addr=0x200, be=4'b1100, wdata=0xBEEF_BEEF; gnt delayed 4 cycles -> stall held 5 cycles.
//  - Misaligned LW: addr=0x301 -> no mem_req_o, misalign_o pulse, stall_o=0.
//  - Timeout: TIMEOUT_CYC=8, never assert gnt -> bus_err_o after 8 REQ cycles, rdata_o=0, FSM returns to IDLE.
//  - DMEM_WBUF_EN: SW 0x400 then LW 0x400 back-to-back -> SW stall_o=0; LW stalls until drain gnt, then returns the stored word.

Source files
------------

// File: rtl/common.sv
// common: shared pipeline types; wrd_size_t encodes the load/store access width.
package common;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} wrd_size_t;
endpackage

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: DM-stage load/store responder on a ready/valid memory bus with lane alignment and extension.
// Define DMEM_WBUF_EN for a 1-entry posted store buffer.
module dmem_access_ctrl
  import common::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_re_i,
  input  logic        dm_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  wrd_size_t   word_size_i,
  input  logic        sign_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_vld_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t     state;
  logic [15:0] cnt;
  logic       sgn, posted;
  logic [1:0] lane;
  wrd_size_t  size;
  logic       req, mis, acc, abort;
  logic [3:0] be;
  logic [31:0] wd, sh, ext;
  assign req = dm_we_i | dm_re_i;
  assign mis = (word_size_i == HALF && addr_i[0]) || (word_size_i == WORD && addr_i[1:0] != 2'b00);
  assign acc = req & !mis;
  assign abort = ((state == REQ && !mem_gnt_i) || (state == WAIT && !mem_rvalid_i)) && cnt == 16'(TIMEOUT_CYC - 1);
  // A posted store drains in REQ without holding the pipeline unless a new request must wait behind it.
  assign stall_o = rst_n & (state == IDLE ? acc & !(WBUF && dm_we_i) : state == DONE ? 1'b0 : posted ? req : 1'b1);
  always_comb begin
    be  = word_size_i == BYTE ? 4'b0001 << addr_i[1:0] : word_size_i == HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'hf;
    wd  = word_size_i == BYTE ? {4{wdata_i[7:0]}} : word_size_i == HALF ? {2{wdata_i[15:0]}} : wdata_i;
    sh  = mem_rdata_i >> {lane, 3'b000};
    ext = size == BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} : size == HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sgn         <= 1'b0;
      posted      <= 1'b0;
      lane        <= 2'b00;
      size        <= BYTE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      rdata_vld_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      rdata_vld_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      if (abort) begin
        bus_err_o <= 1'b1;
        mem_req_o <= 1'b0;
        rdata_o   <= '0;
        posted    <= 1'b0;
        state     <= posted ? IDLE : DONE;
      end else begin
        case (state)
          IDLE: begin
            if (req && mis) misalign_o <= 1'b1;
            if (acc) begin
              state       <= REQ;
              cnt         <= '0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_be_o    <= be;
              mem_wdata_o <= wd;
              size        <= word_size_i;
              sgn         <= sign_i;
              lane        <= addr_i[1:0];
              posted      <= WBUF && dm_we_i;
            end
          end
          REQ: begin
            cnt <= cnt + 16'd1;
            if (mem_gnt_i) begin
              mem_req_o <= 1'b0;
              posted    <= 1'b0;
              state     <= posted ? IDLE : (mem_we_o ? DONE : WAIT);
            end
          end
          WAIT: begin
            cnt <= cnt + 16'd1;
            if (mem_rvalid_i) begin
              rdata_o     <= ext;
              rdata_vld_o <= 1'b1;
              state       <= DONE;
            end
          end
          DONE: state <= IDLE;
        endcase
      end
    end
  end
endmodule
